// File: rtl/fft_frame_sequencer.sv
// fft_frame_sequencer: configures the FFT core once, then feeds it fixed-length sample frames from a small FIFO.
// Optional drain watchdog: define FFT_SEQ_DRAIN_TIMEOUT_EN.
module fft_frame_sequencer #(
    parameter int         FRAME_LEN   = 64,
    parameter int         DATA_W      = 10,
    parameter int         FIFO_DEPTH  = 8,
    parameter int         START_LEVEL = 4,
    parameter logic [7:0] CFG_WORD    = 8'h57,
    parameter int         TIMEOUT     = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              cfg_update,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample_data,
    output logic [7:0]        cfg_tdata,
    output logic              cfg_tvalid,
    input  logic              cfg_tready,
    output logic [31:0]       s_tdata,
    output logic              s_tvalid,
    input  logic              s_tready,
    output logic              s_tlast,
    input  logic              m_tvalid,
    input  logic              m_tlast,
    output logic              frame_busy,
    output logic [15:0]       frames_done,
    output logic              overrun,
    input  logic              overrun_clr,
    output logic              timeout_err
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int FW = $clog2(FRAME_LEN);
    localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] START_CNT = CW'(START_LEVEL);
    localparam logic [FW-1:0] LAST_BEAT = FW'(FRAME_LEN - 1);

    if (FRAME_LEN < 4 || (FRAME_LEN & (FRAME_LEN - 1)) != 0) begin : g_bad_frame
        $error("FRAME_LEN must be a power of 2 and at least 4");
    end
    if (DATA_W < 1 || DATA_W > 16) begin : g_bad_width
        $error("DATA_W must be 1..16");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of 2 and at least 2");
    end
    if (START_LEVEL < 1 || START_LEVEL > FIFO_DEPTH) begin : g_bad_level
        $error("START_LEVEL must be 1..FIFO_DEPTH");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("TIMEOUT must be at least 1");
    end

    typedef enum logic [1:0] {CONFIG, IDLE, STREAM, DRAIN} state_t;

    state_t            state, state_nx;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     rd_ptr, wr_ptr;
    logic [CW-1:0]     count;
    logic [FW-1:0]     beat;
    logic              cfg_pending;
    logic              cfg_fire, pop, push, last_pop, core_done, drain_timeout;

    assign cfg_fire  = cfg_tvalid & cfg_tready;
    assign pop       = s_tvalid & s_tready;
    assign push      = sample_valid & ((count != FULL_CNT) | pop);
    assign last_pop  = pop & (beat == LAST_BEAT);
    assign core_done = m_tvalid & m_tlast;

`ifdef FFT_SEQ_DRAIN_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] drain_cnt;
    assign drain_timeout = (state == DRAIN) & ~core_done & (drain_cnt == TW'(TIMEOUT - 1));
    // Watchdog counts cycles spent waiting for the core's output frame; the error flag is sticky.
    always_ff @(posedge clk) begin
        if (reset) begin
            drain_cnt   <= '0;
            timeout_err <= 1'b0;
        end else begin
            drain_cnt   <= (state == DRAIN) ? drain_cnt + 1'b1 : '0;
            timeout_err <= timeout_err | drain_timeout;
        end
    end
`else
    assign drain_timeout = 1'b0;
    assign timeout_err   = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        state <= reset ? CONFIG : state_nx;
    end

    // Next state: config has priority over a frame start and is only taken from IDLE.
    always_comb begin
        state_nx = state;
        case (state)
            CONFIG:  state_nx = cfg_fire ? IDLE : CONFIG;
            IDLE:    state_nx = cfg_pending ? CONFIG : (enable && count >= START_CNT) ? STREAM : IDLE;
            STREAM:  state_nx = last_pop ? DRAIN : STREAM;
            DRAIN:   state_nx = (core_done | drain_timeout) ? IDLE : DRAIN;
            default: state_nx = CONFIG;
        endcase
    end

    // Outputs decoded from state; cfg_tvalid is masked while reset is held.
    always_comb begin
        cfg_tdata  = CFG_WORD;
        cfg_tvalid = (state == CONFIG) & ~reset;
        s_tvalid   = (state == STREAM) & (count != '0);
        s_tlast    = s_tvalid & (beat == LAST_BEAT);
        s_tdata    = 32'(mem[rd_ptr]);
        frame_busy = (state == STREAM) | (state == DRAIN);
    end

    // FIFO storage; the head entry is presented directly as s_tdata.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= sample_data;
    end

    // FIFO pointers, occupancy and the in-frame beat counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            beat   <= '0;
        end else begin
            rd_ptr <= rd_ptr + AW'(pop);
            wr_ptr <= wr_ptr + AW'(push);
            count  <= count + CW'(push) - CW'(pop);
            beat   <= last_pop ? '0 : beat + FW'(pop);
        end
    end

    // Sticky status: pending config request, completed frame count, dropped-sample flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            cfg_pending <= 1'b1;
            frames_done <= '0;
            overrun     <= 1'b0;
        end else begin
            cfg_pending <= cfg_update | (cfg_pending & ~cfg_fire);
            frames_done <= frames_done + 16'((state == DRAIN) & core_done);
            overrun     <= (sample_valid & ~push) | (overrun & ~overrun_clr);
        end
    end
endmodule
